// File: rtl/collision_pkg.sv
// Shared types and default sizing for the collision scheduler.
package collision_pkg;

  localparam int DEF_NUM_WALLS = 4;
  localparam int DEF_X_W       = 8;
  localparam int DEF_Y_W       = 7;
  localparam int DEF_SCORE_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE,
    ST_OVER
  } state_e;

endpackage

// File: rtl/wall_hit_cmp.sv
// Combinational bird-vs-wall comparison for one slot: hit, passed and respawn flags.
module wall_hit_cmp #(
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int BIRD_W = 8,
  parameter int BIRD_H = 8
) (
  input  logic [X_W-1:0] bird_x,
  input  logic [Y_W-1:0] bird_y,
  input  logic [X_W-1:0] wall_x,
  input  logic [X_W-1:0] wall_w,
  input  logic [Y_W-1:0] gap_top,
  input  logic [Y_W-1:0] gap_bot,
  input  logic           valid,
  output logic           slot_hit,
  output logic           passed,
  output logic           respawned
);

  localparam logic [X_W:0] BW_M1 = (X_W+1)'(BIRD_W - 1);
  localparam logic [Y_W:0] BH_M1 = (Y_W+1)'(BIRD_H - 1);
  localparam logic [X_W:0] X_ONE = (X_W+1)'(1);

  // Right/bottom edges carry one extra bit so sprites near the screen edge never wrap.
  logic [X_W:0] w_bird_r;
  logic [X_W:0] w_wall_r;
  logic [Y_W:0] w_bird_b;
  logic         w_x_ovl;
  logic         w_y_out;

  assign w_bird_r = {1'b0, bird_x} + BW_M1;
  assign w_wall_r = {1'b0, wall_x} + {1'b0, wall_w} - X_ONE;
  assign w_bird_b = {1'b0, bird_y} + BH_M1;

  assign w_x_ovl  = (w_bird_r >= {1'b0, wall_x}) && ({1'b0, bird_x} <= w_wall_r);
  assign w_y_out  = (bird_y < gap_top) || (w_bird_b > {1'b0, gap_bot});

  assign slot_hit  = valid && w_x_ovl && w_y_out;
  assign passed    = valid && ({1'b0, bird_x} > w_wall_r);
  assign respawned = {1'b0, wall_x} > w_bird_r;

endmodule

// File: rtl/collision_sched.sv
// Frame-driven collision scan, one wall slot per cycle through a shared comparator.
// Optional scoring of passed walls is enabled by defining COLLISION_SCORE_EN.
module collision_sched
  import collision_pkg::*;
#(
  parameter int NUM_WALLS = DEF_NUM_WALLS,
  parameter int X_W       = DEF_X_W,
  parameter int Y_W       = DEF_Y_W,
  parameter int BIRD_W    = 8,
  parameter int BIRD_H    = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   frame_tick,
  input  logic                   restart,
  input  logic [X_W-1:0]         bird_x,
  input  logic [Y_W-1:0]         bird_y,
  input  logic [NUM_WALLS*X_W-1:0] wall_x,
  input  logic [X_W-1:0]         wall_w,
  input  logic [NUM_WALLS*Y_W-1:0] gap_top,
  input  logic [NUM_WALLS*Y_W-1:0] gap_bot,
  input  logic [NUM_WALLS-1:0]   wall_valid,
  output logic                   busy,
  output logic                   scan_done,
  output logic                   hit,
  output logic                   game_over,
  output logic [DEF_SCORE_W-1:0] score
);

  localparam int IDX_W   = $clog2(NUM_WALLS);
  localparam int SCORE_W = DEF_SCORE_W;

  state_e           r_state;
  state_e           w_next;
  logic [IDX_W-1:0] r_idx;
  logic [X_W-1:0]   r_bx;
  logic [Y_W-1:0]   r_by;
  logic             r_acc;
  logic             r_hit;
  logic             w_last;
  logic             w_valid;
  logic             w_slot_hit;
  logic             w_passed;
  logic             w_respawned;

  assign w_last  = (r_idx == IDX_W'(NUM_WALLS - 1));
  assign w_valid = wall_valid[r_idx];

  wall_hit_cmp #(
    .X_W    (X_W),
    .Y_W    (Y_W),
    .BIRD_W (BIRD_W),
    .BIRD_H (BIRD_H)
  ) u_cmp (
    .bird_x    (r_bx),
    .bird_y    (r_by),
    .wall_x    (wall_x[int'(r_idx)*X_W +: X_W]),
    .wall_w    (wall_w),
    .gap_top   (gap_top[int'(r_idx)*Y_W +: Y_W]),
    .gap_bot   (gap_bot[int'(r_idx)*Y_W +: Y_W]),
    .valid     (w_valid),
    .slot_hit  (w_slot_hit),
    .passed    (w_passed),
    .respawned (w_respawned)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    // NOTE: every output and the next state get a default first, so no path infers a latch.
    w_next    = r_state;
    busy      = 1'b0;
    scan_done = 1'b0;
    game_over = 1'b0;
    case (r_state)
      ST_IDLE: if (frame_tick) w_next = ST_SCAN;
      ST_SCAN: begin
        busy = 1'b1;
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        scan_done = 1'b1;
        w_next    = r_acc ? ST_OVER : ST_IDLE;
      end
      ST_OVER: game_over = 1'b1;
      default: w_next = ST_IDLE;
    endcase
    if (restart) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    if (!resetn) begin
      r_idx <= '0;
      r_bx  <= '0;
      r_by  <= '0;
      r_acc <= 1'b0;
      r_hit <= 1'b0;
    end else if (restart) begin
      r_idx <= '0;
      r_acc <= 1'b0;
      r_hit <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (frame_tick) begin
          r_idx <= '0;
          r_bx  <= bird_x;
          r_by  <= bird_y;
          r_acc <= 1'b0;
        end
        ST_SCAN: begin
          r_acc <= r_acc | w_slot_hit;
          if (w_last) r_hit <= r_acc | w_slot_hit;
          else        r_idx <= r_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign hit = r_hit;

`ifdef COLLISION_SCORE_EN
  logic [NUM_WALLS-1:0] r_scored;
  logic [SCORE_W-1:0]   r_score;

  // A wall scores once when passed; it re-arms when it leaves or respawns ahead of the bird.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_scored <= '0;
      r_score  <= '0;
    end else if (restart) begin
      r_scored <= '0;
      r_score  <= '0;
    end else if (r_state == ST_SCAN) begin
      if (!w_valid || w_respawned) begin
        r_scored[r_idx] <= 1'b0;
      end else if (w_passed && !r_scored[r_idx]) begin
        r_scored[r_idx] <= 1'b1;
        if (r_score != '1) r_score <= r_score + SCORE_W'(1);
      end
    end
  end

  assign score = r_score;
`else
  logic w_unused_score;
  assign w_unused_score = w_passed ^ w_respawned;
  assign score          = '0;
`endif

endmodule

// File: tb/tb_collision_sched.sv
// Self-checking bench for collision_sched: vector table plus scoreboarded scan results.
module tb_collision_sched;

  localparam int NW = 4;
  localparam int XW = 8;
  localparam int YW = 7;

  logic            clk;
  logic            resetn;
  logic            frame_tick;
  logic            restart;
  logic [XW-1:0]   bird_x;
  logic [YW-1:0]   bird_y;
  logic [NW*XW-1:0] wall_x;
  logic [XW-1:0]   wall_w;
  logic [NW*YW-1:0] gap_top;
  logic [NW*YW-1:0] gap_bot;
  logic [NW-1:0]   wall_valid;
  logic            busy;
  logic            scan_done;
  logic            hit;
  logic            game_over;
  logic [7:0]      score;

  collision_sched dut (
    .clk        (clk),
    .resetn     (resetn),
    .frame_tick (frame_tick),
    .restart    (restart),
    .bird_x     (bird_x),
    .bird_y     (bird_y),
    .wall_x     (wall_x),
    .wall_w     (wall_w),
    .gap_top    (gap_top),
    .gap_bot    (gap_bot),
    .wall_valid (wall_valid),
    .busy       (busy),
    .scan_done  (scan_done),
    .hit        (hit),
    .game_over  (game_over),
    .score      (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

`ifdef COLLISION_SCORE_EN
  localparam int SC_EN = 1;
`else
  localparam int SC_EN = 0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic hit;
    int   tick_cyc;
  } exp_t;
  exp_t exp_q[$];

  // Scoreboard: every scan_done must match the oldest outstanding frame_tick.
  always @(negedge clk) begin
    exp_t e;
    if (resetn && scan_done) begin
      check("scan_done_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("scan_hit", hit, e.hit);
        check("scan_latency", cyc - e.tick_cyc, NW + 1);
      end
    end
  end

  typedef struct {
    logic [7:0] bx;
    logic [6:0] by;
    int         slot;
    logic [7:0] wx;
    logic [7:0] ww;
    logic [6:0] gt;
    logic [6:0] gb;
    logic       v;
    logic       hit;
  } vec_t;
  vec_t vecs[15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_walls();
    wall_x     = {NW{8'd200}};
    gap_top    = '0;
    gap_bot    = {NW{7'd127}};
    wall_valid = '0;
    wall_w     = 8'd10;
  endtask

  task automatic set_slot(input int s, input logic [7:0] wx, input logic [7:0] ww,
                          input logic [6:0] gt, input logic [6:0] gb, input logic v);
    wall_x[s*XW +: XW]  = wx;
    gap_top[s*YW +: YW] = gt;
    gap_bot[s*YW +: YW] = gb;
    wall_valid[s]       = v;
    wall_w              = ww;
  endtask

  task automatic do_restart();
    step();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  task automatic pulse_tick(input logic exp_hit);
    exp_t e;
    step();
    frame_tick = 1'b1;
    e.hit      = exp_hit;
    e.tick_cyc = cyc;
    exp_q.push_back(e);
    step();
    frame_tick = 1'b0;
  endtask

  task automatic run_scan(input logic exp_hit, input string tag);
    int n;
    pulse_tick(exp_hit);
    @(negedge clk);
    check({tag, "_busy"}, busy, 1);
    n = 0;
    while (!scan_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, scan_done, 1);
    if (!scan_done) exp_q.delete();
    @(negedge clk);
    check({tag, "_game_over"}, game_over, exp_hit);
    check({tag, "_idle_after"}, busy, 0);
  endtask

  initial begin
    int exp_score;

    //          bx   by  slot  wx   ww  gt  gb  v  hit
    vecs[0]  = '{40,  50, 0,   44,  10, 40, 70, 1, 0};
    vecs[1]  = '{40,  35, 0,   44,  10, 40, 70, 1, 1};
    vecs[2]  = '{40,  40, 0,   44,  10, 40, 70, 1, 0};
    vecs[3]  = '{40,  39, 0,   44,  10, 40, 70, 1, 1};
    vecs[4]  = '{40,  63, 0,   44,  10, 40, 70, 1, 0};
    vecs[5]  = '{40,  64, 0,   44,  10, 40, 70, 1, 1};
    vecs[6]  = '{40,  35, 0,   48,  10, 40, 70, 1, 0};
    vecs[7]  = '{40,  35, 0,   47,  10, 40, 70, 1, 1};
    vecs[8]  = '{40,  35, 1,   30,  10, 40, 70, 1, 0};
    vecs[9]  = '{40,  35, 1,   30,  11, 40, 70, 1, 1};
    vecs[10] = '{0,   35, 2,   250, 10, 40, 70, 1, 0};
    vecs[11] = '{40,  35, 0,   44,  10, 40, 70, 0, 0};
    vecs[12] = '{40,  35, 3,   44,  10, 40, 70, 1, 1};
    vecs[13] = '{250, 35, 2,   2,   10, 40, 70, 1, 0};
    vecs[14] = '{40,  125, 0,  44,  10, 0, 127, 1, 1};

    resetn     = 1'b0;
    frame_tick = 1'b0;
    restart    = 1'b0;
    bird_x     = '0;
    bird_y     = '0;
    clear_walls();
    #1;
    check("rst_busy", busy, 0);
    check("rst_scan_done", scan_done, 0);
    check("rst_hit", hit, 0);
    check("rst_game_over", game_over, 0);
    check("rst_score", score, 0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", busy, 0);

    for (int i = 0; i < 15; i++) begin
      do_restart();
      clear_walls();
      bird_x = vecs[i].bx;
      bird_y = vecs[i].by;
      set_slot(vecs[i].slot, vecs[i].wx, vecs[i].ww, vecs[i].gt, vecs[i].gb, vecs[i].v);
      run_scan(vecs[i].hit, $sformatf("vec%0d", i));
    end

    // Game over: frame_tick must be ignored while in OVER.
    do_restart();
    clear_walls();
    bird_x = 8'd40;
    bird_y = 7'd35;
    set_slot(0, 8'd44, 8'd10, 7'd40, 7'd70, 1'b1);
    run_scan(1'b1, "over");
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("over_ignores_tick_busy", busy, 0);
    end
    check("over_holds", game_over, 1);

    // Restart coinciding with frame_tick during the second SCAN cycle.
    do_restart();
    check("restart_clears_over", game_over, 0);
    check("restart_clears_hit", hit, 0);
    pulse_tick(1'b1);
    step();
    restart    = 1'b1;
    frame_tick = 1'b1;
    exp_q.delete();
    step();
    restart    = 1'b0;
    frame_tick = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_score", score, 0);
    repeat (8) @(negedge clk);
    check("abort_still_idle", busy, 0);
    run_scan(1'b1, "after_abort");

    // Restart wins over a coincident frame_tick in IDLE.
    do_restart();
    step();
    restart    = 1'b1;
    frame_tick = 1'b1;
    step();
    restart    = 1'b0;
    frame_tick = 1'b0;
    @(negedge clk);
    check("restart_beats_tick", busy, 0);

    // Scoring: pass once, no rescoring, respawn re-arms the slot.
    do_restart();
    clear_walls();
    bird_x = 8'd40;
    bird_y = 7'd50;
    set_slot(1, 8'd20, 8'd10, 7'd0, 7'd127, 1'b1);
    exp_score = SC_EN;
    run_scan(1'b0, "score_a");
    check("score_first_pass", score, exp_score);
    run_scan(1'b0, "score_b");
    run_scan(1'b0, "score_c");
    check("score_no_rescore", score, exp_score);
    set_slot(1, 8'd150, 8'd10, 7'd0, 7'd127, 1'b1);
    run_scan(1'b0, "score_respawn");
    check("score_respawn_hold", score, exp_score);
    set_slot(1, 8'd20, 8'd10, 7'd0, 7'd127, 1'b1);
    exp_score = 2 * SC_EN;
    run_scan(1'b0, "score_d");
    check("score_second_pass", score, exp_score);

    // Asynchronous reset in the middle of a scan.
    pulse_tick(1'b0);
    @(negedge clk);
    check("mid_scan_busy", busy, 1);
    #2 resetn = 1'b0;
    #1;
    exp_q.delete();
    check("async_rst_busy", busy, 0);
    check("async_rst_scan_done", scan_done, 0);
    check("async_rst_hit", hit, 0);
    check("async_rst_game_over", game_over, 0);
    check("async_rst_score", score, 0);
    step();
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_release_idle", busy, 0);
    run_scan(1'b0, "post_reset");
    exp_score = SC_EN;
    check("post_reset_score", score, exp_score);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
